// File: rtl/ram_nrmw_bypass.sv
// Multi-read / multi-write register-file RAM with registered reads, write-first bypass,
// per-entry valid bits for single-cycle bulk clear, and an optional hard-wired zero entry.
module ram_nrmw_bypass #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NR       = 3,
    parameter int NW       = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NR*AW-1:0]    raddr,
    output logic [NR*WIDTH-1:0] rdata,
    input  logic [NW-1:0]       we,
    input  logic [NW*AW-1:0]    waddr,
    input  logic [NW*WIDTH-1:0] wdata,
    input  logic                clear
);

    // Widened compare keeps this meaningful when DEPTH is not a power of two.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < 32'(DEPTH)) && !(ZERO_REG != 0 && a == '0);
    endfunction

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;

    logic [AW-1:0]    w_waddr [NW];
    logic [WIDTH-1:0] w_wdata [NW];
    logic [NW-1:0]    w_wr_ok;

    genvar gj;
    for (gj = 0; gj < NW; gj++) begin : g_wr
        assign w_waddr[gj] = waddr[gj*AW +: AW];
        assign w_wdata[gj] = wdata[gj*WIDTH +: WIDTH];
        assign w_wr_ok[gj] = we[gj] && addr_ok(w_waddr[gj]);
    end

    // Ascending port order: the last NBA to an address (highest port) wins.
    always_ff @(posedge clk) begin
        for (int j = 0; j < NW; j++) begin
            if (w_wr_ok[j]) begin
                r_mem[w_waddr[j]] <= w_wdata[j];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            if (clear) begin
                r_valid <= '0;
            end
            for (int j = 0; j < NW; j++) begin
                if (w_wr_ok[j]) begin
                    r_valid[w_waddr[j]] <= 1'b1;
                end
            end
        end
    end

    genvar gi;
    for (gi = 0; gi < NR; gi++) begin : g_rd
        logic [AW-1:0]    w_ra;
        logic             w_hit;
        logic [WIDTH-1:0] w_byp;
        logic [WIDTH-1:0] w_rd_nxt;
        logic [WIDTH-1:0] r_rdata;

        assign w_ra = raddr[gi*AW +: AW];

        always_comb begin
            w_hit    = 1'b0;
            w_byp    = '0;
            w_rd_nxt = '0;
            for (int j = 0; j < NW; j++) begin
                if (we[j] && w_waddr[j] == w_ra) begin
                    w_hit = 1'b1;
                    w_byp = w_wdata[j];
                end
            end
            if (!addr_ok(w_ra)) begin
                w_rd_nxt = '0;
            end else if (w_hit) begin
                w_rd_nxt = w_byp;
            end else if (clear) begin
                w_rd_nxt = '0;
            end else if (r_valid[w_ra]) begin
                w_rd_nxt = r_mem[w_ra];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_rdata <= '0;
            end else begin
                r_rdata <= w_rd_nxt;
            end
        end

        assign rdata[gi*WIDTH +: WIDTH] = r_rdata;
    end

endmodule

// File: tb/tb_ram_nrmw_bypass.sv
// Bench for ram_nrmw_bypass: two instances (32 entries with zero reg, 24 entries without)
// share stimulus; an array model predicts every read and literal checks pin key cases.
module tb_ram_nrmw_bypass;

    logic        clk;
    logic        rst;
    logic [4:0]  ra [3];
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic [1:0]  wen;
    logic        clr;

    logic [14:0] raddr_p;
    logic [9:0]  waddr_p;
    logic [63:0] wdata_p;
    logic [95:0] rdata_a;
    logic [95:0] rdata_b;
    logic [31:0] rd [2][3];

    int checks = 0;
    int errors = 0;

    assign raddr_p = {ra[2], ra[1], ra[0]};
    assign waddr_p = {wa[1], wa[0]};
    assign wdata_p = {wd[1], wd[0]};

    assign rd[0][0] = rdata_a[31:0];
    assign rd[0][1] = rdata_a[63:32];
    assign rd[0][2] = rdata_a[95:64];
    assign rd[1][0] = rdata_b[31:0];
    assign rd[1][1] = rdata_b[63:32];
    assign rd[1][2] = rdata_b[95:64];

    ram_nrmw_bypass #(.WIDTH(32), .DEPTH(32), .NR(3), .NW(2), .ZERO_REG(1)) dut_a (
        .clk(clk), .rst(rst), .raddr(raddr_p), .rdata(rdata_a),
        .we(wen), .waddr(waddr_p), .wdata(wdata_p), .clear(clr)
    );

    ram_nrmw_bypass #(.WIDTH(32), .DEPTH(24), .NR(3), .NW(2), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .raddr(raddr_p), .rdata(rdata_b),
        .we(wen), .waddr(waddr_p), .wdata(wdata_p), .clear(clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: index 0 = 32 entries with zero reg, index 1 = 24 entries, no zero reg.
    logic [31:0] m_mem [2][32];
    bit          m_val [2][32];
    logic [31:0] m_exp [2][3];

    function automatic int m_depth(input int d);
        return (d == 0) ? 32 : 24;
    endfunction

    function automatic logic [31:0] model_read(input int d, input int a);
        if (d == 0 && a == 0) return 32'h0;
        if (a >= m_depth(d)) return 32'h0;
        for (int j = 1; j >= 0; j--)
            if (wen[j] && int'(wa[j]) == a) return wd[j];
        if (clr) return 32'h0;
        if (m_val[d][a]) return m_mem[d][a];
        return 32'h0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                for (int a = 0; a < 32; a++) m_val[d][a] = 1'b0;
                for (int i = 0; i < 3; i++) m_exp[d][i] = 32'h0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 3; i++) m_exp[d][i] = model_read(d, int'(ra[i]));
                if (clr)
                    for (int a = 0; a < 32; a++) m_val[d][a] = 1'b0;
                for (int j = 0; j < 2; j++) begin
                    if (wen[j] && int'(wa[j]) < m_depth(d) && !(d == 0 && wa[j] == 5'd0)) begin
                        m_mem[d][wa[j]] = wd[j];
                        m_val[d][wa[j]] = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rd[d][i] !== m_exp[d][i]) begin
                    errors++;
                    $display("FAIL model dut%0d port%0d @%0t: got %h expected %h",
                             d, i, $time, rd[d][i], m_exp[d][i]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    task automatic idle();
        wen = 2'b00;
        clr = 1'b0;
        for (int i = 0; i < 3; i++) ra[i] = 5'd0;
        for (int j = 0; j < 2; j++) begin
            wa[j] = 5'd0;
            wd[j] = 32'h0;
        end
    endtask

    task automatic rd_all(input logic [4:0] a);
        for (int i = 0; i < 3; i++) ra[i] = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            chk("reset_a", rd[0][i], 32'h0);
            chk("reset_b", rd[1][i], 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        // T1: every address reads zero after reset
        for (int a = 0; a < 32; a++) begin
            rd_all(5'(a));
            tick();
            for (int i = 0; i < 3; i++) chk("t1_empty", rd[0][i], 32'h0);
        end

        // T2: write then read on all ports
        idle();
        wen = 2'b01; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF;
        tick();
        idle();
        rd_all(5'd5);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t2_rd_a", rd[0][i], 32'hDEADBEEF);
            chk("t2_rd_b", rd[1][i], 32'hDEADBEEF);
        end

        // T3: same-address writes, higher port wins in bypass and storage
        idle();
        wen = 2'b11; wa[0] = 5'd7; wd[0] = 32'h11; wa[1] = 5'd7; wd[1] = 32'h22; ra[0] = 5'd7;
        tick();
        chk("t3_bypass", rd[0][0], 32'h22);
        idle();
        ra[0] = 5'd7;
        tick();
        chk("t3_stored", rd[0][0], 32'h22);
        chk("t3_stored_b", rd[1][0], 32'h22);

        // T4: fill, then clear with a simultaneous write
        for (int a = 1; a < 32; a++) begin
            idle();
            wen = 2'b01; wa[0] = 5'(a); wd[0] = 32'h100 + 32'(a); ra[1] = 5'(a - 1);
            tick();
        end
        idle();
        rd_all(5'd9);
        tick();
        chk("t4_filled", rd[0][0], 32'h109);
        idle();
        clr = 1'b1; wen = 2'b01; wa[0] = 5'd3; wd[0] = 32'h33;
        ra[0] = 5'd9; ra[1] = 5'd3; ra[2] = 5'd4;
        tick();
        chk("t4_clear_same_cycle", rd[0][0], 32'h0);
        chk("t4_bypass_beats_clear", rd[0][1], 32'h33);
        for (int a = 0; a < 32; a++) begin
            idle();
            rd_all(5'(a));
            tick();
            chk("t4_after_clear_a", rd[0][0], (a == 3) ? 32'h33 : 32'h0);
            chk("t4_after_clear_b", rd[1][0], (a == 3) ? 32'h33 : 32'h0);
        end

        // T5: zero entry (instance a) vs ordinary entry 0 (instance b)
        idle();
        wen = 2'b01; wa[0] = 5'd0; wd[0] = 32'hFFFF_FFFF; ra[0] = 5'd0;
        tick();
        chk("t5_zero_now", rd[0][0], 32'h0);
        chk("t5_b_bypass", rd[1][0], 32'hFFFF_FFFF);
        idle();
        tick();
        chk("t5_zero_later", rd[0][0], 32'h0);
        chk("t5_b_stored", rd[1][0], 32'hFFFF_FFFF);

        // T6: out-of-range address on the 24-entry instance
        idle();
        wen = 2'b01; wa[0] = 5'd30; wd[0] = 32'hABCD; ra[0] = 5'd30; ra[1] = 5'd6;
        tick();
        chk("t6_oor_bypass_b", rd[1][0], 32'h0);
        chk("t6_inrange_bypass_a", rd[0][0], 32'hABCD);
        idle();
        ra[0] = 5'd30; ra[1] = 5'd6;
        tick();
        chk("t6_oor_read_b", rd[1][0], 32'h0);
        chk("t6_alias_b", rd[1][1], 32'h0);
        chk("t6_stored_a", rd[0][0], 32'hABCD);

        // Mixed aliasing traffic, checked by the model
        for (int k = 0; k < 40; k++) begin
            wen   = 2'(k % 4);
            wa[0] = 5'((k * 7) % 32);
            wa[1] = 5'((k * 7 + ((k % 3 == 0) ? 0 : 5)) % 32);
            wd[0] = 32'h1000 + 32'(k);
            wd[1] = 32'h2000 + 32'(k);
            ra[0] = wa[0];
            ra[1] = 5'((k * 3) % 32);
            ra[2] = 5'((k * 11) % 32);
            clr   = (k % 13 == 12);
            tick();
        end

        // Asynchronous reset mid-stream with a write pending
        idle();
        wen = 2'b01; wa[0] = 5'd12; wd[0] = 32'h55;
        tick();
        idle();
        rd_all(5'd12);
        tick();
        chk("rst_pre", rd[0][0], 32'h55);
        wen = 2'b01; wa[0] = 5'd13; wd[0] = 32'h66;
        #1;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_async_a", rd[0][i], 32'h0);
            chk("rst_async_b", rd[1][i], 32'h0);
        end
        tick();
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            idle();
            rd_all(5'(a));
            tick();
            chk("rst_after_a", rd[0][0], 32'h0);
            chk("rst_after_b", rd[1][0], 32'h0);
        end

        idle();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
